// File: rtl/mdio_arb.sv
// mdio_arb: round-robin arbiter and sequencer that shares one MDIO bit-level
// driver between NUM_REQ requesters. One PHY register read or write is in
// flight at a time. The block returns the read data and ack status to the
// requester that issued the operation.
//
// Optional feature macro: MDIO_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts an operation whose op_done has not arrived
//   TIMEOUT_CYC cycles after op_exec. The response then reports
//   rsp_timeout = 1, rsp_ack = 1 and rsp_rd_data = 16'hFFFF.
//   When undefined, WAIT exits only on op_done and rsp_timeout stays 0.
//
// Ports:
//   clk, rst_n        system clock; synchronous active-low reset
//   req_valid/rh_wl   per-requester request (1 = read) held until req_ready
//   req_addr          5 bits per requester, requester i at [5i+4:5i]
//   req_wr_data       16 bits per requester, requester i at [16i+15:16i]
//   req_ready         one-hot, one-cycle accept pulse
//   rsp_valid         one-hot, one-cycle completion pulse
//   rsp_rd_data/ack   read data and ack status (0 = acked), valid with rsp_valid
//   rsp_timeout       operation aborted by the watchdog, valid with rsp_valid
//   busy              high whenever the sequencer is not in IDLE
//   op_*              command to the MDIO driver; op_exec is a one-cycle start
//   op_done/rd_data/rd_ack  completion from the MDIO driver
module mdio_arb #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 262144
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_rh_wl,
  input  logic [5*NUM_REQ-1:0]  req_addr,
  input  logic [16*NUM_REQ-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_rd_data,
  output logic                  rsp_ack,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  op_exec,
  output logic                  op_rh_wl,
  output logic [4:0]            op_addr,
  output logic [15:0]           op_wr_data,
  input  logic                  op_done,
  input  logic [15:0]           op_rd_data,
  input  logic                  op_rd_ack
);

  localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [IW-1:0]      ONE_IDX  = IW'(1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      ptr, ptr_nxt;
  logic [IW-1:0]      win, win_nxt;
  logic [IW-1:0]      sel;
  logic               lat_rh_wl, lat_rh_wl_nxt;
  logic [4:0]         lat_addr, lat_addr_nxt;
  logic [15:0]        lat_wr_data, lat_wr_data_nxt;
  logic [NUM_REQ-1:0] req_ready_nxt, rsp_valid_nxt;
  logic [15:0]        rsp_rd_data_nxt;
  logic               rsp_ack_nxt, rsp_timeout_nxt, busy_nxt;
  logic               op_exec_nxt, op_rh_wl_nxt;
  logic [4:0]         op_addr_nxt;
  logic [15:0]        op_wr_data_nxt;
  logic [4:0]         addr_arr [NUM_REQ];
  logic [15:0]        wdat_arr [NUM_REQ];

`ifdef MDIO_ARB_TIMEOUT_EN
  localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYC - 1);
  logic [19:0] wd_cnt, wd_cnt_nxt;
`endif

  // First set bit at or above p, wrapping; the k = 0 candidate is checked
  // last so it overrides any later-in-rotation match.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    logic [IW-1:0] pick;
    pick = p;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (int'(p) + k >= NUM_REQ) idx = IW'(int'(p) + k - NUM_REQ);
      else                        idx = IW'(int'(p) + k);
      if (v[idx]) pick = idx;
    end
    return pick;
  endfunction

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[5*g +: 5];
    assign wdat_arr[g] = req_wr_data[16*g +: 16];
  end

  assign sel = rr_pick(req_valid, ptr);

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    win_nxt         = win;
    lat_rh_wl_nxt   = lat_rh_wl;
    lat_addr_nxt    = lat_addr;
    lat_wr_data_nxt = lat_wr_data;
    req_ready_nxt   = {NUM_REQ{1'b0}};
    rsp_valid_nxt   = {NUM_REQ{1'b0}};
    rsp_rd_data_nxt = rsp_rd_data;
    rsp_ack_nxt     = rsp_ack;
    rsp_timeout_nxt = rsp_timeout;
    op_exec_nxt     = 1'b0;
    op_rh_wl_nxt    = op_rh_wl;
    op_addr_nxt     = op_addr;
    op_wr_data_nxt  = op_wr_data;
`ifdef MDIO_ARB_TIMEOUT_EN
    wd_cnt_nxt      = wd_cnt;
`endif
    case (state)
      IDLE: begin
        if (|req_valid) begin
          win_nxt         = sel;
          req_ready_nxt   = ONE_HOT0 << sel;
          lat_rh_wl_nxt   = req_rh_wl[sel];
          lat_addr_nxt    = addr_arr[sel];
          lat_wr_data_nxt = wdat_arr[sel];
          state_nxt       = GRANT;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        op_rh_wl_nxt   = lat_rh_wl;
        op_addr_nxt    = lat_addr;
        op_wr_data_nxt = lat_wr_data;
        state_nxt      = ISSUE;
      end
      ISSUE: begin
        op_exec_nxt = 1'b1;
`ifdef MDIO_ARB_TIMEOUT_EN
        wd_cnt_nxt  = 20'd0;
`endif
        state_nxt   = WAIT;
      end
      WAIT: begin
        // op_done has priority over a coincident watchdog terminal count.
        if (op_done) begin
          rsp_rd_data_nxt = op_rd_data;
          rsp_ack_nxt     = op_rd_ack;
          rsp_timeout_nxt = 1'b0;
          rsp_valid_nxt   = ONE_HOT0 << win;
          state_nxt       = RESP;
        end
`ifdef MDIO_ARB_TIMEOUT_EN
        else if (wd_cnt == WD_LAST) begin
          rsp_rd_data_nxt = 16'hFFFF;
          rsp_ack_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_valid_nxt   = ONE_HOT0 << win;
          state_nxt       = RESP;
        end else begin
          wd_cnt_nxt = wd_cnt + 20'd1;
        end
`else
        else begin
          state_nxt = WAIT;
        end
`endif
      end
      RESP: begin
        // rsp_valid is already high this cycle; advance the rotation.
        ptr_nxt   = (win == LAST_IDX) ? {IW{1'b0}} : win + ONE_IDX;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= {IW{1'b0}};
      win         <= {IW{1'b0}};
      lat_rh_wl   <= 1'b0;
      lat_addr    <= 5'd0;
      lat_wr_data <= 16'd0;
      req_ready   <= {NUM_REQ{1'b0}};
      rsp_valid   <= {NUM_REQ{1'b0}};
      rsp_rd_data <= 16'd0;
      rsp_ack     <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      op_exec     <= 1'b0;
      op_rh_wl    <= 1'b0;
      op_addr     <= 5'd0;
      op_wr_data  <= 16'd0;
`ifdef MDIO_ARB_TIMEOUT_EN
      wd_cnt      <= 20'd0;
`endif
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      win         <= win_nxt;
      lat_rh_wl   <= lat_rh_wl_nxt;
      lat_addr    <= lat_addr_nxt;
      lat_wr_data <= lat_wr_data_nxt;
      req_ready   <= req_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rd_data <= rsp_rd_data_nxt;
      rsp_ack     <= rsp_ack_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      busy        <= busy_nxt;
      op_exec     <= op_exec_nxt;
      op_rh_wl    <= op_rh_wl_nxt;
      op_addr     <= op_addr_nxt;
      op_wr_data  <= op_wr_data_nxt;
`ifdef MDIO_ARB_TIMEOUT_EN
      wd_cnt      <= wd_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mdio_arb.sv
// Self-checking bench for mdio_arb: directed steps, a behavioural MDIO driver
// model, and scoreboard queues for grants, driver commands and responses.
module tb_mdio_arb;
  localparam int NR = 3;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_rh_wl = '0;
  logic [5*NR-1:0] req_addr = '0;
  logic [16*NR-1:0] req_wr_data = '0;
  logic [NR-1:0]   req_ready, rsp_valid;
  logic [15:0]     rsp_rd_data;
  logic            rsp_ack, rsp_timeout, busy, op_exec, op_rh_wl;
  logic [4:0]      op_addr;
  logic [15:0]     op_wr_data;
  logic            op_done = 1'b0;
  logic [15:0]     op_rd_data = 16'h0000;
  logic            op_rd_ack = 1'b0;

  logic [15:0] drv_data = 16'h0000;
  logic        drv_ack = 1'b0;
  int          drv_delay = 10;
  logic        drv_silent = 1'b0;
  logic        drv_inject = 1'b0;
  int          drv_cnt = 0;
  logic        drv_pend = 1'b0;

  always #5 clk = ~clk;

  mdio_arb #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rh_wl(req_rh_wl),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .rsp_ack(rsp_ack),
    .rsp_timeout(rsp_timeout), .busy(busy), .op_exec(op_exec),
    .op_rh_wl(op_rh_wl), .op_addr(op_addr), .op_wr_data(op_wr_data),
    .op_done(op_done), .op_rd_data(op_rd_data), .op_rd_ack(op_rd_ack)
  );

  // Driver model: answers each op_exec after drv_delay cycles unless silent.
  always @(posedge clk) begin
    op_done <= 1'b0;
    if (!rst_n) begin
      drv_pend <= 1'b0;
    end else if (drv_inject) begin
      op_done    <= 1'b1;
      op_rd_data <= drv_data;
      op_rd_ack  <= drv_ack;
    end else if (op_exec && !drv_silent) begin
      drv_pend <= 1'b1;
      drv_cnt  <= drv_delay;
    end else if (drv_pend) begin
      if (drv_cnt <= 1) begin
        op_done    <= 1'b1;
        op_rd_data <= drv_data;
        op_rd_ack  <= drv_ack;
        drv_pend   <= 1'b0;
      end else begin
        drv_cnt <= drv_cnt - 1;
      end
    end
  end

  typedef struct { logic rh; logic [4:0] addr; logic [15:0] wd; } op_t;
  typedef struct { logic [2:0] who; logic [15:0] rd; logic ack; logic to; } rsp_t;

  logic [2:0] exp_gnt[$];
  op_t        exp_op[$];
  rsp_t       exp_rsp[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_cyc = 0, exec_cyc = 0, done_cyc = 0, rsp_cyc = 0, n_exec = 0;
  int start = 0;
  logic gap_on = 1'b0;
  int rem[NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"},   32'(req_ready),   32'd0);
    chk({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    chk({tag, "_rsp_rd_data"}, 32'(rsp_rd_data), 32'd0);
    chk({tag, "_rsp_ack"},     32'(rsp_ack),     32'd0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({tag, "_busy"},        32'(busy),        32'd0);
    chk({tag, "_op_exec"},     32'(op_exec),     32'd0);
    chk({tag, "_op_rh_wl"},    32'(op_rh_wl),    32'd0);
    chk({tag, "_op_addr"},     32'(op_addr),     32'd0);
    chk({tag, "_op_wr_data"},  32'(op_wr_data),  32'd0);
  endtask

  // One clock; sample on the falling edge and score any DUT events seen.
  task automatic step();
    op_t  eo;
    rsp_t er;
    @(negedge clk);
    cyc++;
    if (op_done) done_cyc = cyc;
    if (req_ready != '0) begin
      ready_cyc = cyc;
      if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'(req_ready), 32'd0);
      else chk("gnt_onehot", 32'(req_ready), 32'(exp_gnt.pop_front()));
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) begin
          rem[i]--;
          if (rem[i] <= 0) req_valid[i] = 1'b0;
        end
      end
    end
    if (op_exec) begin
      exec_cyc = cyc;
      n_exec++;
      chk("busy_in_exec", 32'(busy), 32'd1);
      if (gap_on && n_exec > 1) chk("exec_gap", 32'(exec_cyc - done_cyc), 32'd5);
      if (exp_op.size() == 0) begin
        chk("op_unexpected", 32'(op_exec), 32'd0);
      end else begin
        eo = exp_op.pop_front();
        chk("op_rh_wl",   32'(op_rh_wl),   32'(eo.rh));
        chk("op_addr",    32'(op_addr),    32'(eo.addr));
        chk("op_wr_data", 32'(op_wr_data), 32'(eo.wd));
      end
    end
    if (rsp_valid != '0) begin
      rsp_cyc = cyc;
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        er = exp_rsp.pop_front();
        chk("rsp_valid",   32'(rsp_valid),   32'(er.who));
        chk("rsp_rd_data", 32'(rsp_rd_data), 32'(er.rd));
        chk("rsp_ack",     32'(rsp_ack),     32'(er.ack));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(er.to));
      end
    end
  endtask

  task automatic push(input int i, input logic rh, input logic [4:0] a,
                      input logic [15:0] wd, input logic [15:0] rd,
                      input logic ack, input logic to);
    op_t  o;
    rsp_t r;
    logic [2:0] oh;
    oh = 3'b001 << i;
    o.rh = rh; o.addr = a; o.wd = wd;
    r.who = oh; r.rd = rd; r.ack = ack; r.to = to;
    exp_gnt.push_back(oh);
    exp_op.push_back(o);
    exp_rsp.push_back(r);
  endtask

  task automatic req(input int i, input logic rh, input logic [4:0] a,
                     input logic [15:0] wd, input int n);
    req_rh_wl[i]          = rh;
    req_addr[5*i +: 5]    = a;
    req_wr_data[16*i +: 16] = wd;
    rem[i]                = n;
    req_valid[i]          = 1'b1;
  endtask

  task automatic run_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_rsp.size() != 0 || busy !== 1'b0 || req_valid != '0) && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_drained"}, 32'(exp_rsp.size()), 32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Single read from requester 1, slow driver.
    drv_data = 16'h796D; drv_ack = 1'b0; drv_delay = 100; n_exec = 0;
    push(1, 1'b1, 5'h01, 16'h0000, 16'h796D, 1'b0, 1'b0);
    req(1, 1'b1, 5'h01, 16'h0000, 1);
    start = cyc;
    run_idle("read1", 400);
    chk("read1_ready_lat", 32'(ready_cyc - start), 32'd1);
    chk("read1_exec_lat",  32'(exec_cyc - start),  32'd3);
    chk("read1_rsp_lat",   32'(rsp_cyc - done_cyc), 32'd1);
    chk("read1_n_exec",    32'(n_exec), 32'd1);

    // Write from requester 0; read data returned unmodified.
    drv_data = 16'h5A3C; drv_delay = 7; n_exec = 0;
    push(0, 1'b0, 5'h00, 16'h9140, 16'h5A3C, 1'b0, 1'b0);
    req(0, 1'b0, 5'h00, 16'h9140, 1);
    run_idle("write0", 100);
    chk("write0_n_exec", 32'(n_exec), 32'd1);

    // No-ack read from requester 2; pointer must still advance to 0.
    drv_data = 16'hABCD; drv_ack = 1'b1;
    push(2, 1'b1, 5'h1F, 16'h0000, 16'hABCD, 1'b1, 1'b0);
    req(2, 1'b1, 5'h1F, 16'h0000, 1);
    run_idle("noack2", 100);

    // Stray op_done while idle must be ignored.
    drv_data = 16'h1111; drv_ack = 1'b0; drv_inject = 1'b1;
    step();
    drv_inject = 1'b0;
    repeat (5) step();
    chk("stray_busy",    32'(busy),        32'd0);
    chk("stray_rd_data", 32'(rsp_rd_data), 32'h0000ABCD);
    chk("stray_ack",     32'(rsp_ack),     32'd1);

    // All three requesters held valid: order 0,1,2,0,1,2 back to back.
    drv_data = 16'h2468; drv_delay = 10; n_exec = 0; gap_on = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        push(i, (i != 1), 5'(16 + i), 16'hC000 | 16'(i), 16'h2468, 1'b0, 1'b0);
    for (int i = 0; i < NR; i++) req(i, (i != 1), 5'(16 + i), 16'hC000 | 16'(i), 2);
    run_idle("rr", 400);
    gap_on = 1'b0;
    chk("rr_n_exec", 32'(n_exec), 32'd6);

`ifdef MDIO_ARB_TIMEOUT_EN
    // Silent driver: watchdog completes the operation after TO cycles.
    drv_silent = 1'b1;
    push(1, 1'b1, 5'h03, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
    req(1, 1'b1, 5'h03, 16'h0000, 1);
    run_idle("timeout", 300);
    chk("timeout_lat", 32'(rsp_cyc - exec_cyc), 32'(TO));
    drv_silent = 1'b0; drv_data = 16'h0F0F;
    push(0, 1'b1, 5'h04, 16'h0000, 16'h0F0F, 1'b0, 1'b0);
    req(0, 1'b1, 5'h04, 16'h0000, 1);
    run_idle("after_to", 100);
`endif

    // Normal op from requester 0 moves the pointer to 1.
    drv_data = 16'h3C3C; drv_ack = 1'b1; drv_delay = 5;
    push(0, 1'b1, 5'h06, 16'h0000, 16'h3C3C, 1'b1, 1'b0);
    req(0, 1'b1, 5'h06, 16'h0000, 1);
    run_idle("pre_rst", 100);

    // Reset while requester 1's operation is in WAIT.
    drv_delay = 50; n_exec = 0;
    push(1, 1'b0, 5'h07, 16'h7777, 16'h3C3C, 1'b1, 1'b0);
    req(1, 1'b0, 5'h07, 16'h7777, 1);
    k = 0;
    while (n_exec == 0 && k < 50) begin step(); k++; end
    chk("rst_exec_seen", 32'(n_exec), 32'd1);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk_reset("midrst");
    rst_n = 1'b1;
    chk("rst_pending_rsp", 32'(exp_rsp.size()), 32'd1);
    if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
    repeat (60) step();

    // Pointer back at 0: requester 0 wins over 2, then 2 follows.
    drv_data = 16'h4242; drv_ack = 1'b0; drv_delay = 4;
    push(0, 1'b1, 5'h08, 16'h0000, 16'h4242, 1'b0, 1'b0);
    push(2, 1'b0, 5'h09, 16'hBEEF, 16'h4242, 1'b0, 1'b0);
    req(0, 1'b1, 5'h08, 16'h0000, 1);
    req(2, 1'b0, 5'h09, 16'hBEEF, 1);
    run_idle("post_rst", 200);

    chk("end_gnt_queue", 32'(exp_gnt.size()), 32'd0);
    chk("end_op_queue",  32'(exp_op.size()),  32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdio_arb.md
# mdio_arb

Round-robin arbiter and sequencer that shares the single MDIO bit-level driver (op_exec / op_done interface) between up to NUM_REQ independent requesters: the link/speed monitor, the PHY register configurator and the host register bridge. It accepts one PHY register read or write at a time and presents it to the driver. It then returns the read data and ack status to the requester that issued it. An optional watchdog recovers from a driver that never completes. The block sits between the requesters and the MDIO driver in the Ethernet subsystem.

## Interface
- NUM_REQ, 3: number of requesters, 2..8
- TIMEOUT_CYC, 262144: watchdog limit in clk cycles from op_exec to op_done; range 2..2^20
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- req_valid  in  NUM_REQ  per-requester request; held until matching req_ready
- req_rh_wl  in  NUM_REQ  1 = read, 0 = write
- req_addr  in  5*NUM_REQ  register address, requester i at [5i+4:5i]
- req_wr_data  in  16*NUM_REQ  write data, requester i at [16i+15:16i]
- req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse to the granted requester
- rsp_rd_data  out  16  read data; valid with rsp_valid
- rsp_ack  out  1  0 = PHY acknowledged, 1 = no ack; valid with rsp_valid
- rsp_timeout  out  1  1 = operation aborted by watchdog; valid with rsp_valid
- busy  out  1  high in any state other than IDLE
- op_exec  out  1  1-cycle start pulse to the driver
- op_rh_wl  out  1  to driver
- op_addr  out  5  to driver
- op_wr_data  out  16  to driver
- op_done  in  1  driver completion pulse
- op_rd_data  in  16  driver read data
- op_rd_ack  in  1  driver ack, 0 = acked

## Operation
- All outputs are registered. Reset values: req_ready = 0, rsp_valid = 0, rsp_rd_data = 0, rsp_ack = 0, rsp_timeout = 0, busy = 0, op_exec = 0, op_rh_wl = 0, op_addr = 0, op_wr_data = 0. State = IDLE. Round-robin pointer = 0.

**FSM states: IDLE → GRANT → ISSUE → WAIT → RESP → IDLE.**
- **IDLE:** if any req_valid is high, select the winner and latch its rh_wl, addr and wr_data. Pulse req_ready[winner]. Go to GRANT.
  - Winner rule: the first set bit searching upward from the pointer, wrapping from NUM_REQ-1 to 0.
- **GRANT:** drive op_rh_wl, op_addr and op_wr_data from the latched values. Go to ISSUE.
- **ISSUE:** op_exec = 1 for exactly this cycle. Go to WAIT. The op_* fields stay stable until the next GRANT.
- **WAIT:**
  - On op_done, capture op_rd_data into rsp_rd_data and op_rd_ack into rsp_ack, set rsp_timeout = 0, and go to RESP.
  - For a write, rsp_rd_data holds the captured op_rd_data value unmodified.
- **RESP:** rsp_valid[winner] = 1 for one cycle. Set pointer = (winner+1) mod NUM_REQ. Go to IDLE.

**Boundary conditions**
- op_done outside WAIT is ignored.
- req_valid deasserted before req_ready is a protocol violation; the arbiter must not depend on it.
- Requests arriving while busy wait in place. The pointer guarantees each requester is granted within NUM_REQ operations.
- rst_n low in any state: at the next edge, go to IDLE with reset output values. No rsp_valid is produced for the aborted operation.

## Timing
- req_valid first sampled high in IDLE at edge T:
  - req_ready at T+1
  - op fields valid at T+2
  - op_exec high in cycle T+2 → T+3
- op_done sampled at edge D in WAIT → rsp_valid, rsp_rd_data and rsp_ack valid at D+1.
- Minimum spacing between successive op_exec pulses: op_done + 5 cycles.
- Back-to-back: a requester may re-assert, or hold, req_valid in the cycle of its own rsp_valid; it then competes in the following IDLE cycle.

## Configuration
- **MDIO_ARB_TIMEOUT_EN defined:**
  - A 20-bit counter clears on op_exec and increments in WAIT.
  - When it reaches TIMEOUT_CYC-1 without op_done, the block goes to RESP with rsp_timeout = 1, rsp_ack = 1 and rsp_rd_data = 16'hFFFF.
  - If op_done coincides with that terminal count, op_done wins and no timeout is reported.
  - A late op_done after a timeout is ignored unless it arrives in WAIT of a later operation.
- **Undefined:** no counter. WAIT exits only on op_done. rsp_timeout is constant 0.

## Test plan
- Single read, NUM_REQ = 3, req 1, addr 5'h01; driver returns 16'h796D, ack 0 after 100 cycles → req_ready[1] at T+1, one op_exec with op_addr 01 and op_rh_wl 1, rsp_valid = 3'b010 with data 796D and rsp_ack 0.
- Write, req 0, addr 00, data 16'h9140 → op_rh_wl 0, op_wr_data 9140, one op_exec, rsp_valid = 3'b001.
- All three requesters valid continuously after reset, driver op_done after 10 cycles → grant order 0, 1, 2, 0, 1, 2; exactly one op_exec per grant.
- No-ack: driver returns op_rd_ack = 1 → rsp_ack = 1 delivered to the requester; pointer still advances.
- With MDIO_ARB_TIMEOUT_EN, TIMEOUT_CYC = 64, driver silent → rsp_valid 64 cycles after op_exec with rsp_timeout 1 and data FFFF. Then the next request proceeds normally. An op_done injected in IDLE is ignored.
- rst_n low for one cycle during WAIT → outputs reach reset values at the next edge, no rsp_valid, and the next request is granted to req 0.
